// File: rtl/cn_arith_pkg.sv
// Shared arithmetic-unit definitions: default datapath width, divider
// FSM state encoding and the divide-by-zero quotient constant.
package cn_arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [ARITH_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage : cn_arith_pkg

// File: rtl/restoring_divider_8bit_div_step.sv
// One iteration of restoring division: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;

  // Shift-subtract-restore. The partial remainder stays below the divisor,
  // so the kept value (trial or restored shift) always fits in WIDTH bits.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    trial   = r_shift - {1'b0, d};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule : div_step

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Results are held until the next accepted start.
module restoring_divider_8bit
  import cn_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] r_step, q_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (r_step),
    .q_next (q_step)
  );

  // Next-state, iteration and result-capture logic.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          r_d   = '0;
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            // Zero divisor skips iteration; results are published on this edge.
            state_d     = DIV_DONE;
            quotient_d  = DIV0_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Final step: publish the results on the DONE entry edge so they
          // are valid in the cycle done is high.
          state_d     = DIV_DONE;
          quotient_d  = q_step;
          remainder_d = r_step;
          dbz_d       = 1'b0;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together
      // from the values present before the edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != DIV_IDLE);
  assign done        = (state_q == DIV_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : restoring_divider_8bit

// File: tb/tb_restoring_divider_8bit.sv
// Directed self-checking bench for restoring_divider_8bit. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
module tb_restoring_divider_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  restoring_divider_8bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done after a start already driven at this negedge.
  // Reports the latency in cycles and how many of those cycles had busy high.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_cycles++;
      if (done) return;
    end
    check("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_z, input int exp_lat);
    int lat, bc;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    wait_done(lat, bc);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
    check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp_z));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int saw_done;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("no_done_without_start", 32'(saw_done), 32'd0);

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    repeat (3) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd14);
    check("hold_remainder", 32'(remainder), 32'd2);

    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_div("d5_10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 9);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    run_div("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 9);
    run_div("d128_3", 8'd128, 8'd3, 8'd42, 8'd2, 1'b0, 9);

    run_div("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1);
    run_div("d9_4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 9);

    // Starts while busy (cycle 3 and the done cycle) must be ignored.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    lat = 0;
    saw_done = 0;
    for (int i = 0; i < 20 && saw_done == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 3) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end
      if (done) saw_done = 1;
    end
    check("busy_start_latency", 32'(lat), 32'd9);
    check("busy_start_quotient", 32'(quotient), 32'd14);
    check("busy_start_remainder", 32'(remainder), 32'd2);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_ignored", 32'(busy), 32'd0);
    check("done_cycle_start_result", 32'(quotient), 32'd14);
    run_div("d50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

    // Reset in the middle of RUN.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_div("d63_8", 8'd63, 8'd8, 8'd7, 8'd7, 1'b0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_restoring_divider_8bit
